// File: rtl/mips_pkg.sv
// Shared constants, state and ALU encodings for the multicycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_ADDIEX,
    S_ADDIWB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic alu_ctrl_e funct_to_ctrl(input logic [5:0] fn);
    alu_ctrl_e c;
    case (fn)
      FN_SUB:  c = ALU_SUB;
      FN_AND:  c = ALU_AND;
      FN_OR:   c = ALU_OR;
      FN_SLT:  c = ALU_SLT;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu(input alu_ctrl_e c, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    case (c)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports, one sync write port, x0 fixed at 0.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned TAP_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       raddr1_i,
  input  logic [4:0]       raddr2_i,
  output logic [31:0]      rdata1_o,
  output logic [31:0]      rdata2_o,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [4:0]       tap_addr_i,
  output logic [TAP_W-1:0] tap_data_o
);

  logic [31:0] regs_q [32];

  // Storage: async clear, writes to x0 dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o   = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];
  assign tap_data_o = regs_q[tap_addr_i][TAP_W-1:0];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core with a single req/ready memory port, trap and retire count.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TEST_W   = 16,
  parameter logic [4:0]  TEST_REG = 5'd2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              CLK,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       PC,
  output logic              trap,
  output logic [CNT_W-1:0]  retired,
  output logic [TEST_W-1:0] test_value
);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       aluout_q, aluout_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              trap_q, trap_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic [31:0]       rf_rdata1, rf_rdata2;

  logic [5:0]        op;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic [5:0]        fn;
  logic [31:0]       imm_sx;
  logic [31:0]       ea;
  logic [31:0]       br_target;

  assign op        = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign imm       = ir_q[15:0];
  assign fn        = ir_q[5:0];
  assign imm_sx    = sext16(imm);
  assign ea        = a_q + imm_sx;
  assign br_target = (a_q == b_q) ? aluout_q : pc_q;

  mips_regfile #(.TAP_W(TEST_W)) u_regfile (
    .clk_i      (CLK),
    .rst_ni     (rst),
    .raddr1_i   (rs),
    .raddr2_i   (rt),
    .rdata1_o   (rf_rdata1),
    .rdata2_o   (rf_rdata2),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .tap_addr_i (TEST_REG),
    .tap_data_o (test_value)
  );

  // State, datapath and registered memory-port outputs.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      mdr_q     <= '0;
      trap_q    <= 1'b0;
      retired_q <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluout_q  <= aluout_d;
      mdr_q     <= mdr_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next-state and datapath control. The memory port is registered, so each
  // transition into an access state loads req/addr/wdata for that access.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    trap_d    = trap_q;
    retired_d = retired_q;
    req_d     = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;

    unique case (state_q)
      S_FETCH: begin
        if (req_q && mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end else begin
          // Covers both the first cycle out of reset and memory wait cycles.
          req_d  = 1'b1;
          addr_d = pc_q;
        end
      end
      S_DECODE: begin
        a_d      = rf_rdata1;
        b_d      = rf_rdata2;
        aluout_d = pc_q + {imm_sx[29:0], 2'b00};
        case (op)
          OP_RTYPE: state_d = funct_legal(fn) ? S_EXECUTE : S_TRAP;
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) trap_d = 1'b1;
      end
      S_MEMADR: begin
        aluout_d = ea;
        if (ea[1:0] != 2'b00) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else if (op == OP_LW) begin
          state_d = S_MEMREAD;
          req_d   = 1'b1;
          addr_d  = ea;
        end else begin
          state_d = S_MEMWRITE;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = ea;
          wdata_d = b_q;
        end
      end
      S_MEMREAD: begin
        if (req_q && mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end else begin
          req_d = 1'b1;
        end
      end
      S_MEMWB: begin
        rf_we     = 1'b1;
        rf_waddr  = rt;
        rf_wdata  = mdr_q;
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
        req_d     = 1'b1;
        addr_d    = pc_q;
      end
      S_MEMWRITE: begin
        if (req_q && mem_ready) begin
          state_d   = S_FETCH;
          retired_d = retired_q + CNT_W'(1);
          req_d     = 1'b1;
          addr_d    = pc_q;
        end else begin
          req_d = 1'b1;
          we_d  = 1'b1;
        end
      end
      S_EXECUTE: begin
        aluout_d = alu(funct_to_ctrl(fn), a_q, b_q);
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we     = 1'b1;
        rf_waddr  = rd;
        rf_wdata  = aluout_q;
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
        req_d     = 1'b1;
        addr_d    = pc_q;
      end
      S_ADDIEX: begin
        aluout_d = ea;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we     = 1'b1;
        rf_waddr  = rt;
        rf_wdata  = aluout_q;
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
        req_d     = 1'b1;
        addr_d    = pc_q;
      end
      S_BRANCH: begin
        pc_d      = br_target;
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
        req_d     = 1'b1;
        addr_d    = br_target;
      end
      S_JUMP: begin
        pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
        req_d     = 1'b1;
        addr_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
      end
      S_TRAP: begin
        trap_d = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
      end
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign PC        = pc_q;
  assign trap      = trap_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core with a bus-transaction scoreboard.
module tb_mips_multicycle_core;

  localparam logic [31:0] R = 32'h1000_0000;

  logic        CLK;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, PC, retired;
  logic [15:0] test_value;

  logic [31:0] pmem [1024];
  logic [31:0] dmem [1024];
  int unsigned data_wait;
  int unsigned wcnt;
  bit          sb_on;
  int unsigned n_pass, n_total, n_fail;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  txn_t sb_q[$];

  mips_multicycle_core #(
    .RESET_PC (R),
    .TEST_W   (16),
    .TEST_REG (5'd2),
    .CNT_W    (32)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .PC         (PC),
    .trap       (trap),
    .retired    (retired),
    .test_value (test_value)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Code lives at 0x1xxx_xxxx with zero wait; data at 0x0xxx_xxxx with data_wait waits.
  assign mem_rdata = mem_addr[28] ? pmem[mem_addr[11:2]] : dmem[mem_addr[11:2]];
  assign mem_ready = !mem_req ? 1'b1 : (mem_addr[28] ? 1'b1 : (wcnt >= data_wait));

  always @(posedge CLK or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge CLK) begin
    if (rst && mem_req && mem_ready && mem_we && !mem_addr[28])
      dmem[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every cycle a request is up, it must match the head expected transaction.
  always @(negedge CLK) begin
    txn_t t;
    if (rst && sb_on && mem_req) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        t = sb_q[0];
        check("sb_addr", mem_addr, t.addr);
        check("sb_we", {31'b0, mem_we}, {31'b0, t.we});
        if (t.we) check("sb_wdata", mem_wdata, t.wdata);
        if (mem_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic exp_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wd;
    sb_q.push_back(t);
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    sb_on = 1'b0;
    sb_q.delete();
    data_wait = 0;
    for (int i = 0; i < 1024; i++) pmem[i] = 32'h0;
    tick(2);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_pc", PC, R);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_tv", {16'h0, test_value}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    rst = 1'b1;
  endtask

  task automatic wait_retired(input int unsigned n, output int unsigned cyc);
    cyc = 0;
    while (retired !== n && cyc < 100) begin
      tick(1);
      cyc++;
    end
    check("retired_reach", retired, n);
  endtask

  logic [31:0] p2_ofs [15];
  logic [31:0] p2_word[15];
  logic [15:0] p2_tv  [15];
  int unsigned p2_cyc [15];
  int unsigned cyc;

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    rst = 1'b0; data_wait = 0; sb_on = 1'b0;

    // ---- Run 1: addi/addi/add, sw/lw with data waits, beq loop ----
    do_reset();
    pmem[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
    pmem[1] = enc_i(6'h08, 5'd0, 5'd3, 16'd7);
    pmem[2] = enc_r(5'd2, 5'd3, 5'd2, 6'h20);
    pmem[3] = enc_i(6'h2B, 5'd0, 5'd2, 16'd8);
    pmem[4] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
    pmem[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'd12);
    pmem[6] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    exp_txn(1'b0, R + 32'h00, 32'h0);
    exp_txn(1'b0, R + 32'h04, 32'h0);
    exp_txn(1'b0, R + 32'h08, 32'h0);
    exp_txn(1'b0, R + 32'h0C, 32'h0);
    exp_txn(1'b1, 32'd8, 32'd12);
    exp_txn(1'b0, R + 32'h10, 32'h0);
    exp_txn(1'b0, 32'd8, 32'h0);
    exp_txn(1'b0, R + 32'h14, 32'h0);
    exp_txn(1'b1, 32'd12, 32'd12);
    repeat (3) exp_txn(1'b0, R + 32'h18, 32'h0);
    data_wait = 3;
    sb_on = 1'b1;
    release_reset();
    tick(1);
    check("first_req", {31'b0, mem_req}, 32'd1);
    check("first_addr", mem_addr, R);
    check("first_we", {31'b0, mem_we}, 32'd0);
    tick(11);
    check("r1_ret2", retired, 32'd2);
    check("r1_tv5", {16'h0, test_value}, 32'd5);
    tick(1);
    check("r1_ret3", retired, 32'd3);
    check("r1_tv12", {16'h0, test_value}, 32'd12);
    check("r1_trap", {31'b0, trap}, 32'd0);
    tick(6);
    check("sw_wait_req", {31'b0, mem_req}, 32'd1);
    check("sw_wait_we", {31'b0, mem_we}, 32'd1);
    check("sw_wait_addr", mem_addr, 32'd8);
    check("sw_wait_wdata", mem_wdata, 32'd12);
    check("sw_wait_ret", retired, 32'd3);
    tick(1);
    check("sw_done_ret", retired, 32'd4);
    check("sw_done_we", {31'b0, mem_we}, 32'd0);
    check("sw_done_addr", mem_addr, R + 32'h10);
    tick(7);
    check("lw_memwb_ret", retired, 32'd4);
    check("lw_memwb_req", {31'b0, mem_req}, 32'd0);
    tick(1);
    check("lw_done_ret", retired, 32'd5);
    tick(7);
    check("sw2_done_ret", retired, 32'd6);
    tick(3);
    check("beq1_pc", PC, R + 32'h18);
    check("beq1_ret", retired, 32'd7);
    tick(1);
    check("beq_fetch_pc", PC, R + 32'h1C);
    tick(2);
    check("beq2_pc", PC, R + 32'h18);
    check("beq2_ret", retired, 32'd8);
    tick(3);
    check("beq3_ret", retired, 32'd9);
    sb_on = 1'b0;
    check("r1_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- Run 2: jump, R-type mix, signed slt, x0 write, beq not taken ----
    do_reset();
    p2_ofs = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50,
               32'h54, 32'h58, 32'h5C, 32'h60, 32'h64, 32'h68, 32'h6C};
    p2_word[0]  = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
    p2_word[1]  = enc_i(6'h08, 5'd2, 5'd2, 16'd1);
    p2_word[2]  = {6'h02, 26'h10};
    p2_word[3]  = enc_i(6'h08, 5'd2, 5'd2, 16'd4);
    p2_word[4]  = enc_i(6'h08, 5'd0, 5'd5, 16'hFFFD);
    p2_word[5]  = enc_r(5'd5, 5'd2, 5'd2, 6'h2A);
    p2_word[6]  = enc_r(5'd2, 5'd5, 5'd2, 6'h22);
    p2_word[7]  = enc_i(6'h08, 5'd0, 5'd6, 16'd10);
    p2_word[8]  = enc_r(5'd2, 5'd6, 5'd2, 6'h25);
    p2_word[9]  = enc_r(5'd2, 5'd5, 5'd2, 6'h24);
    p2_word[10] = enc_i(6'h08, 5'd0, 5'd0, 16'd5);
    p2_word[11] = enc_r(5'd0, 5'd6, 5'd2, 6'h20);
    p2_word[12] = enc_r(5'd6, 5'd5, 5'd2, 6'h2A);
    p2_word[13] = enc_r(5'd5, 5'd6, 5'd2, 6'h22);
    p2_word[14] = enc_i(6'h04, 5'd2, 5'd0, 16'd5);
    p2_tv  = '{16'd1, 16'd2, 16'd2, 16'd6, 16'd6, 16'd1, 16'd4, 16'd4,
               16'd14, 16'd12, 16'd12, 16'd10, 16'd0, 16'hFFF3, 16'hFFF3};
    p2_cyc = '{4, 4, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 3};
    for (int i = 0; i < 15; i++) begin
      pmem[p2_ofs[i][11:2]] = p2_word[i];
      exp_txn(1'b0, R + p2_ofs[i], 32'h0);
    end
    pmem[32'h0C >> 2] = enc_i(6'h08, 5'd0, 5'd2, 16'h0077);
    pmem[32'h84 >> 2] = enc_i(6'h08, 5'd0, 5'd2, 16'h0055);
    pmem[32'h70 >> 2] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    sb_on = 1'b1;
    release_reset();
    tick(1);
    for (int i = 0; i < 15; i++) begin
      wait_retired(i + 1, cyc);
      check($sformatf("p2_tv_%0d", i), {16'h0, test_value}, {16'h0, p2_tv[i]});
      check($sformatf("p2_cyc_%0d", i), cyc, p2_cyc[i]);
    end
    sb_on = 1'b0;
    check("p2_sb_empty", 32'(sb_q.size()), 32'd0);
    check("p2_pc_nt", PC, R + 32'h70);

    // ---- Run 3: illegal opcode 0x3F traps after DECODE ----
    do_reset();
    pmem[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd9);
    pmem[1] = 32'hFC00_0000;
    exp_txn(1'b0, R, 32'h0);
    exp_txn(1'b0, R + 32'h4, 32'h0);
    sb_on = 1'b1;
    release_reset();
    tick(1);
    wait_retired(1, cyc);
    tick(1);
    check("ill_decode_trap", {31'b0, trap}, 32'd0);
    tick(1);
    check("ill_trap", {31'b0, trap}, 32'd1);
    check("ill_req", {31'b0, mem_req}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(3);
      check("ill_req_hold", {31'b0, mem_req}, 32'd0);
    end
    check("ill_trap_hold", {31'b0, trap}, 32'd1);
    check("ill_ret", retired, 32'd1);
    check("ill_pc", PC, R + 32'h8);
    check("ill_tv", {16'h0, test_value}, 32'd9);
    sb_on = 1'b0;
    check("ill_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- Run 4: misaligned lw traps after MEMADR ----
    do_reset();
    pmem[0] = enc_i(6'h23, 5'd0, 5'd4, 16'd6);
    exp_txn(1'b0, R, 32'h0);
    sb_on = 1'b1;
    release_reset();
    tick(3);
    check("mis_pre_trap", {31'b0, trap}, 32'd0);
    tick(1);
    check("mis_trap", {31'b0, trap}, 32'd1);
    check("mis_req", {31'b0, mem_req}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(3);
      check("mis_req_hold", {31'b0, mem_req}, 32'd0);
    end
    check("mis_ret", retired, 32'd0);
    check("mis_pc", PC, R + 32'h4);
    sb_on = 1'b0;
    check("mis_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- Run 5: async reset in the middle of a waiting MEMREAD ----
    do_reset();
    pmem[0] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
    data_wait = 5;
    release_reset();
    tick(4);
    check("mr_req", {31'b0, mem_req}, 32'd1);
    check("mr_addr", mem_addr, 32'd8);
    tick(1);
    check("mr_hold_addr", mem_addr, 32'd8);
    check("mr_hold_we", {31'b0, mem_we}, 32'd0);
    rst = 1'b0;
    #1;
    check("mr_rst_req", {31'b0, mem_req}, 32'd0);
    check("mr_rst_pc", PC, R);
    check("mr_rst_addr", mem_addr, 32'd0);
    release_reset();
    tick(1);
    check("mr_rel_req", {31'b0, mem_req}, 32'd1);
    check("mr_rel_addr", mem_addr, R);
    tick(1);
    check("mr_rel_pc", PC, R + 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
